pc_fetch_unit: RTL and testbench
================================

# pc_fetch_unit

Program-counter and instruction-fetch stage of the single-cycle datapath. Holds the architectural PC, drives instruction memory through a req/ack handshake, and presents the fetched instruction to decode. Produces PC+4 (`Exit_ALU_Pc`) for the branch-select mux. Consumes that mux's selected next PC (`NewInput_Pc`) as its load value.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `TIMEOUT`, default 16: cycles in FETCH without ack before the error is declared (range 1..255).

Ports:
- `clock`, in, 1: single clock; all state updates on rising edge.
- `reset`, in, 1: asynchronous, active-high.
- `NewInput_Pc`, in, 32: next PC from the branch-select mux.
- `Stall`, in, 1: hold the current instruction and PC.
- `Imem_Ack`, in, 1: instruction memory data valid this cycle.
- `Imem_Data`, in, 32: instruction word, sampled only with ack.
- `Imem_Req`, out, 1: fetch request.
- `Imem_Addr`, out, 32: fetch address; equals the PC.
- `Exit_Pc`, out, 32: current PC.
- `Exit_ALU_Pc`, out, 32: PC + 4, combinational from the PC register.
- `Instr`, out, 32: latched instruction.
- `Instr_Valid`, out, 1: `Instr` is valid for execution.
- `Fetch_Error`, out, 1: sticky error flag.

## Operation
- States:
  - IDLE: reset state, `Imem_Req`=0.
  - FETCH: `Imem_Req`=1.
  - EXEC: `Instr_Valid`=1.
  - ERROR: `Fetch_Error`=1, `Imem_Req`=0.
- Transitions:
  - IDLE to FETCH unconditionally on the first edge after reset release.
  - FETCH with `Imem_Ack`=1: latch `Instr` from `Imem_Data`, clear the timeout counter, go to EXEC.
  - FETCH with `Imem_Ack`=0: increment the timeout counter. When the counter reaches `TIMEOUT`, go to ERROR.
  - EXEC with `Stall`=0: PC loads `NewInput_Pc`, go to FETCH.
  - EXEC with `Stall`=1: stay in EXEC. PC, `Instr` and `Instr_Valid` are held.
  - ERROR: held until reset.
- Ack arriving in the same cycle the counter hits `TIMEOUT`: the ack wins and the state goes to EXEC.
- `Imem_Ack` outside FETCH is ignored. `Instr` is unchanged.
- `Stall` outside EXEC has no effect.
- `Exit_ALU_Pc` = PC + 4, modulo 2^32. 32'hFFFF_FFFC yields 32'h0000_0000.
- Reset values:
  - PC = `RESET_PC`
  - `Instr` = 0
  - `Instr_Valid` = 0
  - `Imem_Req` = 0
  - `Fetch_Error` = 0
  - counter = 0
  - state = IDLE
- Reset asserted mid-fetch or mid-stall returns all of the above immediately. The pending request is dropped.

## Timing
- Zero-wait memory: 2 cycles per instruction (FETCH then EXEC).
- Each wait cycle adds 1 cycle.
- `Instr_Valid` rises the cycle after the ack is sampled.
- The PC update is visible on `Exit_Pc`/`Imem_Addr` in the FETCH cycle that follows EXEC.
- First `Imem_Req` is asserted 1 cycle after reset release.
- `Imem_Addr` is stable for the whole FETCH residency.

## Configuration
- `PC_ALIGN_CHECK_EN` defined: in EXEC with `Stall`=0, if `NewInput_Pc[1:0]` != 0 the PC is not loaded and the state goes to ERROR (`Fetch_Error`=1 next cycle).
- `PC_ALIGN_CHECK_EN` undefined: the PC loads `{NewInput_Pc[31:2], 2'b00}` and no error is raised.

## Structure
- Shared package `pc_fetch_pkg`:
  - state enumeration (IDLE, FETCH, EXEC, ERROR)
  - `PC_INCR` = 4
  - `PC_ALIGN_MASK` = 32'h0000_0003
- One sub-module, `fetch_timeout_cnt`:
  - 8-bit counter with clear/enable and a terminal-count output compared against `TIMEOUT`.
  - Same clock and asynchronous reset as the parent.

## Test plan
- Reset with `RESET_PC`=0x0000_0040: outputs all zero, `Exit_Pc`=0x40, `Exit_ALU_Pc`=0x44. First `Imem_Req` appears 1 cycle after release.
- Ack in the first FETCH cycle with `Imem_Data`=0x8C01_0004, `NewInput_Pc`=0x44: `Instr`=0x8C01_0004 and `Instr_Valid`=1 for one cycle, then `Imem_Addr`=0x44. Repeats every 2 cycles.
- `Stall`=1 for 3 cycles in EXEC: `Instr_Valid` and PC are held for 3 cycles. A spurious `Imem_Ack` during the stall leaves `Instr` unchanged.
- No ack with `TIMEOUT`=4: ERROR after 4 FETCH cycles, `Fetch_Error`=1, `Imem_Req`=0 until reset. A second run with the ack on cycle 4 goes to EXEC with no error.
- Branch target `NewInput_Pc`=0x0000_0102:
  - with `PC_ALIGN_CHECK_EN`: ERROR, PC stays at the old value.
  - without it: PC=0x100.
- PC=0xFFFF_FFFC: `Exit_ALU_Pc`=0x0000_0000. Reset asserted mid-wait clears the state to IDLE within the same cycle.

Source files
------------

// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the PC/fetch stage: FSM states, PC increment, word-alignment mask.
// Used by pc_fetch_unit; PC_ALIGN_CHECK_EN in the top selects trap-vs-truncate on misaligned targets.
package pc_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    ERROR = 2'd3
  } fetch_state_t;

  localparam logic [31:0] PC_INCR       = 32'd4;
  localparam logic [31:0] PC_ALIGN_MASK = 32'h0000_0003;

  function automatic logic [31:0] pc_align(input logic [31:0] pc);
    return pc & ~PC_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/fetch_timeout_cnt.sv
// Fetch wait-cycle counter: 8-bit, clear has priority over enable, no output latency on term.
// term flags that the next enabled increment reaches TIMEOUT, so the parent can leave on that edge.
module fetch_timeout_cnt #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic term
);

  logic [7:0] count;
  logic [7:0] count_inc;

  assign count_inc = count + 8'd1;
  assign term      = (count_inc == 8'(TIMEOUT));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= 8'd0;
    end else if (clr) begin
      count <= 8'd0;
    end else if (en) begin
      count <= count_inc;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register + imem req/ack fetch FSM; 2 cycles/instr at zero wait, +1 per wait cycle, TIMEOUT waits -> sticky ERROR.
// Stall holds EXEC (PC/Instr frozen); PC_ALIGN_CHECK_EN traps misaligned targets, otherwise low PC bits are dropped.
module pc_fetch_unit
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] NewInput_Pc,
  input  logic        Stall,
  input  logic        Imem_Ack,
  input  logic [31:0] Imem_Data,
  output logic        Imem_Req,
  output logic [31:0] Imem_Addr,
  output logic [31:0] Exit_Pc,
  output logic [31:0] Exit_ALU_Pc,
  output logic [31:0] Instr,
  output logic        Instr_Valid,
  output logic        Fetch_Error
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q;
  logic [31:0]  instr_q;
  logic         pc_load;
  logic         instr_load;
  logic         cnt_clr;
  logic         cnt_en;
  logic         cnt_term;

  fetch_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clock (clock),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .term  (cnt_term)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_load     = 1'b0;
    instr_load  = 1'b0;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    Imem_Req    = 1'b0;
    Instr_Valid = 1'b0;
    Fetch_Error = 1'b0;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        Imem_Req = 1'b1;
        // ack takes priority over a timeout landing on the same edge
        if (Imem_Ack) begin
          instr_load = 1'b1;
          cnt_clr    = 1'b1;
          state_d    = EXEC;
        end else begin
          cnt_en = 1'b1;
          if (cnt_term) state_d = ERROR;
        end
      end
      EXEC: begin
        Instr_Valid = 1'b1;
        if (!Stall) begin
`ifdef PC_ALIGN_CHECK_EN
          if (|(NewInput_Pc & PC_ALIGN_MASK)) begin
            state_d = ERROR;
          end else begin
            pc_load = 1'b1;
            state_d = FETCH;
          end
`else
          pc_load = 1'b1;
          state_d = FETCH;
`endif
        end
      end
      ERROR: Fetch_Error = 1'b1;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
    end else begin
      if (pc_load)    pc_q    <= pc_align(NewInput_Pc);
      if (instr_load) instr_q <= Imem_Data;
    end
  end

  assign Imem_Addr   = pc_q;
  assign Exit_Pc     = pc_q;
  assign Exit_ALU_Pc = pc_q + PC_INCR;
  assign Instr       = instr_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit (RESET_PC=0x40, TIMEOUT=4); honours PC_ALIGN_CHECK_EN if defined.
// Inputs change and outputs are sampled on the falling edge; the DUT updates on the rising edge.
module tb_pc_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0040;
  localparam int          TO     = 4;

  logic        clock;
  logic        reset;
  logic [31:0] NewInput_Pc;
  logic        Stall;
  logic        Imem_Ack;
  logic [31:0] Imem_Data;
  logic        Imem_Req;
  logic [31:0] Imem_Addr;
  logic [31:0] Exit_Pc;
  logic [31:0] Exit_ALU_Pc;
  logic [31:0] Instr;
  logic        Instr_Valid;
  logic        Fetch_Error;

  int total = 0;
  int bad   = 0;

  pc_fetch_unit #(.RESET_PC(RST_PC), .TIMEOUT(TO)) dut (
    .clock       (clock),
    .reset       (reset),
    .NewInput_Pc (NewInput_Pc),
    .Stall       (Stall),
    .Imem_Ack    (Imem_Ack),
    .Imem_Data   (Imem_Data),
    .Imem_Req    (Imem_Req),
    .Imem_Addr   (Imem_Addr),
    .Exit_Pc     (Exit_Pc),
    .Exit_ALU_Pc (Exit_ALU_Pc),
    .Instr       (Instr),
    .Instr_Valid (Instr_Valid),
    .Fetch_Error (Fetch_Error)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reset, release on a falling edge, then advance into the first FETCH cycle.
  task automatic start();
    @(negedge clock);
    reset = 1'b1; Stall = 1'b0; Imem_Ack = 1'b0; Imem_Data = 32'd0; NewInput_Pc = 32'd0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1; Stall = 1'b0; Imem_Ack = 1'b1; Imem_Data = 32'hDEAD_BEEF; NewInput_Pc = 32'h1234;
    #1;
    total++;
    if ({Imem_Req, Instr_Valid, Fetch_Error} !== 3'b000 || Instr !== 32'd0) begin
      bad++; $display("FAIL reset_outputs: req/vld/err=%b instr=%h, want 000 and 0", {Imem_Req, Instr_Valid, Fetch_Error}, Instr);
    end
    total++;
    if (Exit_Pc !== RST_PC || Imem_Addr !== RST_PC || Exit_ALU_Pc !== RST_PC + 32'd4) begin
      bad++; $display("FAIL reset_pc: pc=%h addr=%h alu=%h, want 40/40/44", Exit_Pc, Imem_Addr, Exit_ALU_Pc);
    end
    Imem_Ack = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    total++;
    if (Imem_Req !== 1'b0) begin bad++; $display("FAIL req_at_release: got %b want 0", Imem_Req); end
    @(negedge clock);
    total++;
    if (Imem_Req !== 1'b1 || Imem_Addr !== RST_PC) begin
      bad++; $display("FAIL first_req: req=%b addr=%h want 1/%h", Imem_Req, Imem_Addr, RST_PC);
    end
  endtask

  task automatic test_basic();
    logic [31:0] d;
    start();
    for (int i = 0; i < 3; i++) begin
      d = 32'h8C01_0004 + (i << 16);
      Imem_Ack = 1'b1; Imem_Data = d; NewInput_Pc = 32'h44 + 32'(4 * i);
      @(negedge clock);
      total++;
      if (Instr !== d || Instr_Valid !== 1'b1 || Imem_Req !== 1'b0) begin
        bad++; $display("FAIL basic_exec%0d: instr=%h vld=%b req=%b want %h/1/0", i, Instr, Instr_Valid, Imem_Req, d);
      end
      Imem_Ack = 1'b0;
      @(negedge clock);
      total++;
      if (Imem_Addr !== 32'h44 + 32'(4 * i) || Imem_Req !== 1'b1 || Instr_Valid !== 1'b0) begin
        bad++; $display("FAIL basic_fetch%0d: addr=%h req=%b vld=%b want %h/1/0", i, Imem_Addr, Imem_Req, Instr_Valid, 32'h44 + 32'(4 * i));
      end
    end
  endtask

  task automatic test_stall();
    start();
    Imem_Ack = 1'b1; Imem_Data = 32'hA5A5_0001; NewInput_Pc = 32'h0000_0200;
    @(negedge clock);
    Stall = 1'b1; Imem_Ack = 1'b1; Imem_Data = 32'h1111_2222;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      total++;
      if (Instr_Valid !== 1'b1 || Instr !== 32'hA5A5_0001 || Exit_Pc !== RST_PC || Imem_Req !== 1'b0) begin
        bad++; $display("FAIL stall_hold%0d: vld=%b instr=%h pc=%h req=%b want 1/a5a50001/%h/0", i, Instr_Valid, Instr, Exit_Pc, Imem_Req, RST_PC);
      end
    end
    Stall = 1'b0; Imem_Ack = 1'b0;
    @(negedge clock);
    total++;
    if (Imem_Req !== 1'b1 || Exit_Pc !== 32'h200 || Instr_Valid !== 1'b0 || Instr !== 32'hA5A5_0001) begin
      bad++; $display("FAIL stall_release: req=%b pc=%h vld=%b instr=%h want 1/200/0/a5a50001", Imem_Req, Exit_Pc, Instr_Valid, Instr);
    end
  endtask

  task automatic test_timeout();
    start();
    for (int i = 0; i < TO; i++) begin
      total++;
      if (Imem_Req !== 1'b1 || Fetch_Error !== 1'b0) begin
        bad++; $display("FAIL timeout_wait%0d: req=%b err=%b want 1/0", i, Imem_Req, Fetch_Error);
      end
      @(negedge clock);
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (Fetch_Error !== 1'b1 || Imem_Req !== 1'b0 || Instr_Valid !== 1'b0) begin
        bad++; $display("FAIL timeout_err%0d: err=%b req=%b vld=%b want 1/0/0", i, Fetch_Error, Imem_Req, Instr_Valid);
      end
      Imem_Ack = 1'b1; Stall = 1'(i);
      @(negedge clock);
    end
    Imem_Ack = 1'b0; Stall = 1'b0;
    start();
    for (int i = 0; i < TO - 1; i++) @(negedge clock);
    Imem_Ack = 1'b1; Imem_Data = 32'h0BAD_F00D; NewInput_Pc = 32'h80;
    @(negedge clock);
    Imem_Ack = 1'b0;
    total++;
    if (Instr_Valid !== 1'b1 || Fetch_Error !== 1'b0 || Instr !== 32'h0BAD_F00D) begin
      bad++; $display("FAIL ack_at_limit: vld=%b err=%b instr=%h want 1/0/0badf00d", Instr_Valid, Fetch_Error, Instr);
    end
  endtask

  task automatic test_align();
    start();
    Imem_Ack = 1'b1; Imem_Data = 32'h1; NewInput_Pc = 32'h0000_0102;
    @(negedge clock);
    Imem_Ack = 1'b0;
    @(negedge clock);
`ifdef PC_ALIGN_CHECK_EN
    total++;
    if (Fetch_Error !== 1'b1 || Exit_Pc !== RST_PC || Imem_Req !== 1'b0) begin
      bad++; $display("FAIL align_trap: err=%b pc=%h req=%b want 1/%h/0", Fetch_Error, Exit_Pc, Imem_Req, RST_PC);
    end
`else
    total++;
    if (Fetch_Error !== 1'b0 || Exit_Pc !== 32'h100 || Imem_Req !== 1'b1) begin
      bad++; $display("FAIL align_trunc: err=%b pc=%h req=%b want 0/100/1", Fetch_Error, Exit_Pc, Imem_Req);
    end
`endif
  endtask

  task automatic test_wrap_midreset();
    start();
    Imem_Ack = 1'b1; Imem_Data = 32'h7; NewInput_Pc = 32'hFFFF_FFFC;
    @(negedge clock);
    Imem_Ack = 1'b0;
    @(negedge clock);
    total++;
    if (Exit_Pc !== 32'hFFFF_FFFC || Exit_ALU_Pc !== 32'h0000_0000) begin
      bad++; $display("FAIL pc_wrap: pc=%h alu=%h want fffffffc/00000000", Exit_Pc, Exit_ALU_Pc);
    end
    @(negedge clock);
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    total++;
    if (Imem_Req !== 1'b0 || Exit_Pc !== RST_PC || Instr !== 32'd0 || Instr_Valid !== 1'b0) begin
      bad++; $display("FAIL midwait_reset: req=%b pc=%h instr=%h vld=%b want 0/%h/0/0", Imem_Req, Exit_Pc, Instr, Instr_Valid, RST_PC);
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    for (int i = 0; i < TO - 1; i++) @(negedge clock);
    Imem_Ack = 1'b1; Imem_Data = 32'h55;
    @(negedge clock);
    Imem_Ack = 1'b0;
    total++;
    if (Instr_Valid !== 1'b1 || Fetch_Error !== 1'b0) begin
      bad++; $display("FAIL counter_cleared: vld=%b err=%b want 1/0", Instr_Valid, Fetch_Error);
    end
  endtask

  // Transaction-level model: each instruction is (waits, data, stalls, next target);
  // the PC only advances to the word-aligned target once the instruction leaves EXEC.
  task automatic test_random();
    logic [31:0] pc_m, data, nxt;
    int          waits, stalls;
    start();
    pc_m = RST_PC;
    for (int n = 0; n < 40; n++) begin
      waits  = $urandom_range(0, TO - 1);
      stalls = $urandom_range(0, 3);
      data   = $urandom;
      nxt    = $urandom;
`ifdef PC_ALIGN_CHECK_EN
      nxt[1:0] = 2'b00;
`endif
      for (int k = 0; k <= waits; k++) begin
        total++;
        if (Imem_Req !== 1'b1 || Imem_Addr !== pc_m || Exit_ALU_Pc !== pc_m + 32'd4 || Instr_Valid !== 1'b0 || Fetch_Error !== 1'b0) begin
          bad++; $display("FAIL rand_fetch n=%0d k=%0d: req=%b addr=%h alu=%h vld=%b err=%b want 1/%h/%h/0/0",
                          n, k, Imem_Req, Imem_Addr, Exit_ALU_Pc, Instr_Valid, Fetch_Error, pc_m, pc_m + 32'd4);
        end
        Imem_Ack  = (k == waits);
        Imem_Data = (k == waits) ? data : $urandom;
        Stall     = 1'($urandom);
        @(negedge clock);
      end
      for (int s = 0; s <= stalls; s++) begin
        total++;
        if (Instr_Valid !== 1'b1 || Instr !== data || Exit_Pc !== pc_m || Imem_Req !== 1'b0) begin
          bad++; $display("FAIL rand_exec n=%0d s=%0d: vld=%b instr=%h pc=%h req=%b want 1/%h/%h/0",
                          n, s, Instr_Valid, Instr, Exit_Pc, Imem_Req, data, pc_m);
        end
        Stall       = (s < stalls);
        Imem_Ack    = 1'($urandom);
        Imem_Data   = $urandom;
        NewInput_Pc = (s < stalls) ? $urandom : nxt;
        @(negedge clock);
      end
      Imem_Ack = 1'b0; Stall = 1'b0;
      pc_m = nxt & ~32'h3;
    end
  endtask

  initial begin
    reset = 1'b1; Stall = 1'b0; Imem_Ack = 1'b0; Imem_Data = 32'd0; NewInput_Pc = 32'd0;
    test_reset();
    test_basic();
    test_stall();
    test_timeout();
    test_align();
    test_wrap_midreset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
